// File: rtl/ppu_hazard_stall_controller.sv
// PPU 5-stage pipeline sequencing: load-use stall, forwarding selects,
// memory-busy freeze with timeout, and stall statistics.
module ppu_hazard_stall_controller #(
   parameter int REG_W       = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_rf_enable,
   input  logic             id_load_instr,
   input  logic             mem_busy,
   output logic             pc_le,
   output logic             ifid_le,
   output logic             pipe_le,
   output logic             cu_nop_sel,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_WB  = 2'b11;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             we;
      logic             ld;
   } sb_t;

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;
   logic             timeout_set;

   sb_t sb_ex;
   sb_t sb_mem;
   sb_t sb_wb;
   sb_t id_entry;

   logic ex_ld_live;
   logic hit_rs_ld;
   logic hit_rt_ld;
   logic hazard;

   // Load in EX whose destination is read by the instruction in ID
   always_comb begin
      ex_ld_live = sb_ex.ld && sb_ex.we && (sb_ex.dest != '0);
      hit_rs_ld  = id_uses_rs && (id_rs == sb_ex.dest);
      hit_rt_ld  = id_uses_rt && (id_rt == sb_ex.dest);
      hazard     = id_valid && ex_ld_live && (hit_rs_ld || hit_rt_ld);
   end

   function automatic logic [1:0] fwd_pick(
      input logic [REG_W-1:0] src,
      input sb_t              ex,
      input sb_t              mem,
      input sb_t              wb
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (src != '0) begin
         if (ex.we && !ex.ld && (ex.dest == src))
            sel = SEL_EX;
         else if (mem.we && (mem.dest == src))
            sel = SEL_MEM;
         else if (wb.we && (wb.dest == src))
            sel = SEL_WB;
      end
      return sel;
   endfunction

   // Operand bypass selects, youngest producer first
   always_comb begin
      fwd_a_sel = fwd_pick(id_rs, sb_ex, sb_mem, sb_wb);
      fwd_b_sel = fwd_pick(id_rt, sb_ex, sb_mem, sb_wb);
   end

   // Sequencing FSM: enables, bubble insert, wait timer
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      timeout_set = 1'b0;
      pc_le       = 1'b1;
      ifid_le     = 1'b1;
      pipe_le     = 1'b1;
      cu_nop_sel  = 1'b0;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               pc_le     = 1'b0;
               ifid_le   = 1'b0;
               pipe_le   = 1'b0;
               timer_nxt = TMR_W'(1);
               state_nxt = MEM_WAIT;
            end else if (hazard) begin
               pc_le      = 1'b0;
               ifid_le    = 1'b0;
               cu_nop_sel = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!mem_busy) begin
               state_nxt = RUN;
               timer_nxt = '0;
               if (hazard) begin
                  pc_le      = 1'b0;
                  ifid_le    = 1'b0;
                  cu_nop_sel = 1'b1;
               end
            end else begin
               pc_le   = 1'b0;
               ifid_le = 1'b0;
               pipe_le = 1'b0;
               if (timer == TMR_LAST) begin
                  state_nxt   = TIMEOUT;
                  timeout_set = 1'b1;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
         end
         TIMEOUT: begin
            pc_le   = 1'b0;
            ifid_le = 1'b0;
            pipe_le = 1'b0;
         end
         default: begin
            state_nxt = RUN;
            timer_nxt = '0;
         end
      endcase
   end

   // Entry for the instruction leaving ID (bubble when squashed)
   always_comb begin
      id_entry.dest = id_dest;
      id_entry.we   = id_rf_enable && id_valid;
      id_entry.ld   = id_load_instr && id_valid;
      if (cu_nop_sel)
         id_entry = '0;
   end

   // State, timer and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= RUN;
         timer       <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (timeout_set)
            mem_timeout <= 1'b1;
      end
   end

   // Destination scoreboard shifts with the pipeline registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sb_ex  <= '0;
         sb_mem <= '0;
         sb_wb  <= '0;
      end else if (pipe_le) begin
         sb_wb  <= sb_mem;
         sb_mem <= sb_ex;
         sb_ex  <= id_entry;
      end
   end

   // Saturating count of cycles where the PC did not advance
   always_ff @(posedge clk) begin
      if (!reset_n)
         stall_count <= '0;
      else if (!pc_le && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + 1'b1;
   end

endmodule
